sdr_protocol_checker: RTL and testbench

- Passive, parametrised SDRAM command-bus protocol checker. Tracks the state of every bank purely from the decoded {cs_n, ras_n, cas_n, we_n, ba, addr} stream, with no controller-internal taps.
- Adds timing checks (tRCD, tRP, tRAS, tRFC, tMRD) and registered error reporting.
- Instantiated alongside the sdr_bus interface in simulation and FPGA debug builds; drives no bus signal.

---
 rtl/sdr_protocol_checker.sv | 191 +++++++++++++++++++
 tb/tb_sdr_protocol_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sdr_protocol_checker.sv
// sdr_protocol_checker: passive SDRAM command-bus checker with per-bank state/timing tracking.
// Define SDR_CHK_ASSERT_EN to add per-code assertions and per-bank transition covers.
module sdr_protocol_checker #(
   parameter int BA_W  = 2,
   parameter int T_RCD = 3,
   parameter int T_RP  = 3,
   parameter int T_RAS = 6,
   parameter int T_RFC = 9,
   parameter int T_MRD = 2,
   parameter int CNT_W = 4
) (
   input  logic                 sdram_clk,
   input  logic                 sdram_reset,
   input  logic                 chk_en,
   input  logic                 sdr_cke,
   input  logic                 sdr_cs_n,
   input  logic                 sdr_ras_n,
   input  logic                 sdr_cas_n,
   input  logic                 sdr_we_n,
   input  logic [BA_W-1:0]      sdr_ba,
   input  logic                 sdr_addr10,
   output logic [2**BA_W-1:0]   bank_open,
   output logic                 ref_busy,
   output logic                 err_valid,
   output logic [3:0]           err_code,
   output logic [BA_W-1:0]      err_bank,
   output logic [15:0]          err_cnt
);
   localparam int NUM_BANKS = 2**BA_W;
   localparam logic [CNT_W-1:0] SAT   = '1;
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] RCD_C = CNT_W'(T_RCD);
   localparam logic [CNT_W-1:0] RP_C  = CNT_W'(T_RP);
   localparam logic [CNT_W-1:0] RAS_C = CNT_W'(T_RAS);
   localparam logic [CNT_W-1:0] RFC_C = CNT_W'(T_RFC);
   localparam logic [CNT_W-1:0] MRD_C = CNT_W'(T_MRD);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   typedef enum logic {B_IDLE, B_ACTIVE} bank_st_e;

   bank_st_e         bank_st [NUM_BANKS];
   logic [CNT_W-1:0] act_t   [NUM_BANKS];
   logic [CNT_W-1:0] prech_t [NUM_BANKS];
   logic [CNT_W-1:0] ref_t, mrd_t;

   logic [3:0]          cmd;
   logic                cmd_xz;
   logic                is_nop, is_act, is_rdwr, is_pre, is_ref, is_mrs;
   logic [NUM_BANKS-1:0] open_v;
   logic                any_open, ras_hit, apply;
   logic [BA_W-1:0]     ras_bank, chk_bank;
   logic [3:0]          chk_code;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == SAT) ? v : v + ONE;
   endfunction

   assign cmd    = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
   assign cmd_xz = sdr_cke && ((^cmd) === 1'bx);

   always_comb begin
      is_nop  = !sdr_cke || sdr_cs_n || (cmd == CMD_NOP) || cmd_xz;
      is_act  = !is_nop && (cmd == CMD_ACT);
      is_rdwr = !is_nop && ((cmd == CMD_RD) || (cmd == CMD_WR));
      is_pre  = !is_nop && (cmd == CMD_PRE);
      is_ref  = !is_nop && (cmd == CMD_REF);
      is_mrs  = !is_nop && (cmd == CMD_MRS);
      for (int i = 0; i < NUM_BANKS; i++) open_v[i] = (bank_st[i] == B_ACTIVE);
      any_open = |open_v;

      // PRE-all scans downward so the lowest offending bank is the one reported
      ras_hit  = 1'b0;
      ras_bank = '0;
      if (is_pre) begin
         if (sdr_addr10) begin
            for (int i = NUM_BANKS-1; i >= 0; i--) begin
               if (open_v[i] && (act_t[i] < RAS_C)) begin
                  ras_hit  = 1'b1;
                  ras_bank = BA_W'(i);
               end
            end
         end else if (open_v[sdr_ba] && (act_t[sdr_ba] < RAS_C)) begin
            ras_hit  = 1'b1;
            ras_bank = sdr_ba;
         end
      end

      // Evaluated from highest to lowest code so the lowest applicable code wins
      chk_code = 4'd0;
      chk_bank = sdr_ba;
      if (cmd_xz) begin
         chk_code = 4'd10;
      end else if (!is_nop) begin
         if (mrd_t < MRD_C)                        chk_code = 4'd9;
         if (is_mrs && any_open)                   chk_code = 4'd8;
         if (ref_t < RFC_C)                        chk_code = 4'd7;
         if (is_ref && any_open)                   chk_code = 4'd6;
         if (ras_hit) begin
            chk_code = 4'd5;
            chk_bank = ras_bank;
         end
         if (is_rdwr && (act_t[sdr_ba] < RCD_C))   chk_code = 4'd4;
         if (is_rdwr && !open_v[sdr_ba])           chk_code = 4'd3;
         if (is_act && (prech_t[sdr_ba] < RP_C))   chk_code = 4'd2;
         if (is_act && open_v[sdr_ba])             chk_code = 4'd1;
      end

      // State-rule violations are rejected; timing violations still execute on the device
      apply = !is_nop && (chk_code != 4'd1) && (chk_code != 4'd3) &&
              (chk_code != 4'd6) && (chk_code != 4'd8);

      bank_open = open_v;
      ref_busy  = (ref_t < RFC_C) || (mrd_t < MRD_C);
   end

   always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            bank_st[i] <= B_IDLE;
            act_t[i]   <= SAT;
            prech_t[i] <= SAT;
         end
         ref_t     <= SAT;
         mrd_t     <= SAT;
         err_valid <= 1'b0;
         err_code  <= 4'd0;
         err_bank  <= '0;
         err_cnt   <= 16'd0;
      end else begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            act_t[i]   <= sat_inc(act_t[i]);
            prech_t[i] <= sat_inc(prech_t[i]);
         end
         ref_t <= sat_inc(ref_t);
         mrd_t <= sat_inc(mrd_t);
         if (apply) begin
            if (is_act) begin
               bank_st[sdr_ba] <= B_ACTIVE;
               act_t[sdr_ba]   <= ONE;
            end
            if (is_pre && sdr_addr10) begin
               for (int i = 0; i < NUM_BANKS; i++) begin
                  bank_st[i] <= B_IDLE;
                  prech_t[i] <= ONE;
               end
            end else if (is_pre || (is_rdwr && sdr_addr10)) begin
               bank_st[sdr_ba] <= B_IDLE;
               prech_t[sdr_ba] <= ONE;
            end
            if (is_ref) ref_t <= ONE;
            if (is_mrs) mrd_t <= ONE;
         end
         err_valid <= chk_en && (chk_code != 4'd0);
         if (chk_en && (chk_code != 4'd0)) begin
            err_code <= chk_code;
            err_bank <= chk_bank;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
         end
      end
   end

`ifdef SDR_CHK_ASSERT_EN
   logic [3:0] cmd_q;
   always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) cmd_q <= CMD_NOP;
      else             cmd_q <= cmd;
   end

   for (genvar c = 1; c <= 10; c++) begin : g_code
      a_err: assert property (@(posedge sdram_clk) disable iff (sdram_reset)
         !(err_valid && (err_code == 4'(c))))
         else $error("%0t sdr_protocol_checker code %0d bank %0d cmd %b",
                     $time, err_code, err_bank, cmd_q);
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_cov
      c_open:  cover property (@(posedge sdram_clk) disable iff (sdram_reset)
         !open_v[b] ##1 open_v[b]);
      c_close: cover property (@(posedge sdram_clk) disable iff (sdram_reset)
         open_v[b] ##1 !open_v[b]);
   end
`endif

endmodule

// File: tb/tb_sdr_protocol_checker.sv
// Directed bench for sdr_protocol_checker: legal flows, each error class, chk_en gating, async reset.
module tb_sdr_protocol_checker;
   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] RD  = 4'b0101;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] REF = 4'b0001;
   localparam logic [3:0] MRS = 4'b0000;

   logic        sdram_clk = 1'b0;
   logic        sdram_reset = 1'b1;
   logic        chk_en = 1'b1;
   logic        sdr_cke = 1'b1;
   logic        sdr_cs_n = 1'b0, sdr_ras_n = 1'b1, sdr_cas_n = 1'b1, sdr_we_n = 1'b1;
   logic [1:0]  sdr_ba = 2'd0;
   logic        sdr_addr10 = 1'b0;
   logic [3:0]  bank_open;
   logic        ref_busy, err_valid;
   logic [3:0]  err_code;
   logic [1:0]  err_bank;
   logic [15:0] err_cnt;

   int checks = 0;
   int errors = 0;

   always #5 sdram_clk = ~sdram_clk;

   sdr_protocol_checker dut (
      .sdram_clk  (sdram_clk),
      .sdram_reset(sdram_reset),
      .chk_en     (chk_en),
      .sdr_cke    (sdr_cke),
      .sdr_cs_n   (sdr_cs_n),
      .sdr_ras_n  (sdr_ras_n),
      .sdr_cas_n  (sdr_cas_n),
      .sdr_we_n   (sdr_we_n),
      .sdr_ba     (sdr_ba),
      .sdr_addr10 (sdr_addr10),
      .bank_open  (bank_open),
      .ref_busy   (ref_busy),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .err_bank   (err_bank),
      .err_cnt    (err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one command from a falling edge; returns at the next falling edge
   task automatic tick(input logic [3:0] c, input logic [1:0] b, input logic a10);
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
      sdr_ba     = b;
      sdr_addr10 = a10;
      @(negedge sdram_clk);
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) tick(NOP, 2'd0, 1'b0);
   endtask

   task automatic expect_err(input string tag, input logic [3:0] code,
                             input logic [1:0] bank, input logic [15:0] cnt);
      chk({tag, "_valid"}, 32'(err_valid), 32'd1);
      chk({tag, "_code"},  32'(err_code),  32'(code));
      chk({tag, "_bank"},  32'(err_bank),  32'(bank));
      chk({tag, "_cnt"},   32'(err_cnt),   32'(cnt));
   endtask

   initial begin
      repeat (2) @(negedge sdram_clk);
      sdram_reset = 1'b0;
      chk("rst_open",  32'(bank_open), 32'h0);
      chk("rst_busy",  32'(ref_busy),  32'h0);
      chk("rst_valid", 32'(err_valid), 32'h0);
      chk("rst_code",  32'(err_code),  32'h0);
      chk("rst_bank",  32'(err_bank),  32'h0);
      chk("rst_cnt",   32'(err_cnt),   32'h0);

      // Legal ACT/RD/PRE/ACT on bank 1 at exactly the minimum spacings
      tick(ACT, 2'd1, 1'b0);
      chk("t1_act_open", 32'(bank_open), 32'b0010);
      chk("t1_act_ok",   32'(err_valid), 32'd0);
      nops(2); tick(RD, 2'd1, 1'b0);
      chk("t1_rd_ok", 32'(err_valid), 32'd0);
      nops(2); tick(PRE, 2'd1, 1'b0);
      chk("t1_pre_open", 32'(bank_open), 32'b0000);
      chk("t1_pre_ok",   32'(err_valid), 32'd0);
      nops(2); tick(ACT, 2'd1, 1'b0);
      chk("t1_act2_open", 32'(bank_open), 32'b0010);
      chk("t1_act2_ok",   32'(err_valid), 32'd0);
      chk("t1_cnt",       32'(err_cnt),   32'd0);

      // tRCD violation on bank 2
      tick(ACT, 2'd2, 1'b0);
      chk("t2_act_open", 32'(bank_open), 32'b0110);
      nops(1); tick(RD, 2'd2, 1'b0);
      expect_err("t2_rcd", 4'd4, 2'd2, 16'd1);
      chk("t2_open_kept", 32'(bank_open), 32'b0110);
      nops(1);
      chk("t2_pulse_end", 32'(err_valid), 32'd0);

      // ACT to an already active bank; act_t must not reload
      tick(ACT, 2'd0, 1'b0);
      nops(3); tick(ACT, 2'd0, 1'b0);
      expect_err("t3_act_open", 4'd1, 2'd0, 16'd2);
      nops(1); tick(PRE, 2'd0, 1'b0);
      chk("t3_pre_ok",   32'(err_valid), 32'd0);
      chk("t3_pre_open", 32'(bank_open), 32'b0110);

      // REF with open banks, then tRFC window
      tick(PRE, 2'd0, 1'b1);
      chk("t4_preall_ok",   32'(err_valid), 32'd0);
      chk("t4_preall_open", 32'(bank_open), 32'b0000);
      nops(2); tick(ACT, 2'd0, 1'b0); tick(ACT, 2'd3, 1'b0);
      chk("t4_act_ok",   32'(err_valid), 32'd0);
      chk("t4_act_open", 32'(bank_open), 32'b1001);
      tick(REF, 2'd0, 1'b0);
      expect_err("t4_ref_open", 4'd6, 2'd0, 16'd3);
      chk("t4_ref_rejected", 32'(ref_busy), 32'd0);
      nops(4); tick(PRE, 2'd0, 1'b1);
      chk("t4_close_ok",   32'(err_valid), 32'd0);
      chk("t4_close_open", 32'(bank_open), 32'b0000);
      tick(REF, 2'd0, 1'b0);
      chk("t4_ref_ok",   32'(err_valid), 32'd0);
      chk("t4_ref_busy", 32'(ref_busy),  32'd1);
      nops(4); tick(ACT, 2'd1, 1'b0);
      expect_err("t4_rfc", 4'd7, 2'd1, 16'd4);
      chk("t4_rfc_applied", 32'(bank_open), 32'b0010);
      chk("t4_rfc_busy",    32'(ref_busy),  32'd1);
      nops(3); tick(ACT, 2'd2, 1'b0);
      chk("t4_rfc_done_ok", 32'(err_valid), 32'd0);
      chk("t4_rfc_open",    32'(bank_open), 32'b0110);
      chk("t4_busy_clear",  32'(ref_busy),  32'd0);

      // PRE-all inside tRAS on banks 1 and 3
      nops(5); tick(PRE, 2'd0, 1'b1);
      chk("t5_close_ok", 32'(err_valid), 32'd0);
      nops(2); tick(ACT, 2'd1, 1'b0); tick(ACT, 2'd3, 1'b0);
      chk("t5_act_open", 32'(bank_open), 32'b1010);
      nops(3); tick(PRE, 2'd2, 1'b1);
      expect_err("t5_ras", 4'd5, 2'd1, 16'd5);
      chk("t5_all_idle", 32'(bank_open), 32'b0000);

      // chk_en=0 suppresses errors
      chk_en = 1'b0;
      tick(RD, 2'd2, 1'b0);
      chk("t6_gated_valid", 32'(err_valid), 32'd0);
      chk("t6_gated_cnt",   32'(err_cnt),   32'd5);
      chk_en = 1'b1;
      tick(REF, 2'd0, 1'b0);
      chk("t6_ref_ok", 32'(err_valid), 32'd0);
      tick(ACT, 2'd2, 1'b0);
      expect_err("t6_rfc", 4'd7, 2'd2, 16'd6);
      chk("t6_open", 32'(bank_open), 32'b0100);
      chk("t6_busy", 32'(ref_busy),  32'd1);

      // Asynchronous reset between clock edges
      #2 sdram_reset = 1'b1;
      #1;
      chk("arst_open",  32'(bank_open), 32'h0);
      chk("arst_busy",  32'(ref_busy),  32'h0);
      chk("arst_valid", 32'(err_valid), 32'h0);
      chk("arst_code",  32'(err_code),  32'h0);
      chk("arst_bank",  32'(err_bank),  32'h0);
      chk("arst_cnt",   32'(err_cnt),   32'h0);
      @(negedge sdram_clk);
      sdram_reset = 1'b0;

      // tMRD window, then WR inside tRCD
      tick(MRS, 2'd0, 1'b0);
      chk("t7_mrs_ok",   32'(err_valid), 32'd0);
      chk("t7_mrs_busy", 32'(ref_busy),  32'd1);
      tick(ACT, 2'd0, 1'b0);
      expect_err("t7_mrd", 4'd9, 2'd0, 16'd1);
      chk("t7_mrd_busy_clear", 32'(ref_busy),  32'd0);
      chk("t7_mrd_applied",    32'(bank_open), 32'b0001);
      tick(WR, 2'd0, 1'b0);
      expect_err("t7_wr_rcd", 4'd4, 2'd0, 16'd2);
      nops(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
